// File: rtl/lsu_pkg.sv
// Shared types for the data-memory port arbiter and its
// committed-store buffer.
package lsu_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        valid;
   } sb_entry_t;

   typedef enum logic {
      LOAD_PRI  = 1'b0,
      STORE_PRI = 1'b1
   } arb_state_e;

   // Byte strobes to the DM's active-low per-bit write enable.
   function automatic logic [31:0] strb_to_wmask(
      input logic [3:0] strb
   );
      logic [31:0] m;
      for (int k = 0; k < 4; k++) begin
         m[8*k +: 8] = {8{~strb[k]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/commit_store_buffer.sv
// Circular FIFO of retired stores with a word-address match
// against every pending entry for load ordering.
module commit_store_buffer
   import lsu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [31:0]            push_addr,
   input  logic [31:0]            push_data,
   input  logic [3:0]             push_strb,
   input  logic                   pop,
   input  logic [29:0]            lookup_word,
   output logic                   hit,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count_next,
   output sb_entry_t              head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   sb_entry_t     mem_q [DEPTH];
   sb_entry_t     mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      if (pop) begin
         mem_d[head_q].valid = 1'b0;
         head_d = head_q + PW'(1);
      end
      if (push) begin
         mem_d[tail_q] = '{addr:  push_addr,
                           data:  push_data,
                           strb:  push_strb,
                           valid: 1'b1};
         tail_d = tail_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_q[i].valid &&
             mem_q[i].addr[31:2] == lookup_word)
            hit = 1'b1;
      end
   end

   assign empty      = (count_q == '0);
   assign full       = (count_q == CW'(DEPTH));
   assign count_next = count_d;
   assign head       = mem_q[head_q];

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port DM owner: arbitrates LSU loads against the
// committed-store buffer, with hazard blocking and fence drain.
module dm_port_arbiter
   import lsu_pkg::*;
#(
   parameter int SB_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int TAG_W        = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_req_valid,
   input  logic [31:0]      ld_req_addr,
   input  logic [TAG_W-1:0] ld_req_tag,
   output logic             ld_req_ready,
   output logic             ld_rsp_valid,
   output logic [TAG_W-1:0] ld_rsp_tag,
   output logic [31:0]      ld_rsp_data,
   input  logic             st_commit_valid,
   input  logic [31:0]      st_commit_addr,
   input  logic [31:0]      st_commit_data,
   input  logic [3:0]       st_commit_strb,
   output logic             st_commit_ready,
   input  logic             fence_req,
   output logic             fence_done,
   input  logic [31:0]      DM_rd_data,
   output logic             DM_c_en,
   output logic             DM_r_en,
   output logic [31:0]      DM_w_en,
   output logic [31:0]      DM_addr,
   output logic [31:0]      DM_w_data
);
   localparam int CW = $clog2(SB_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_e       state_q, state_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   logic             sb_push, sb_hit;
   logic             sb_empty, sb_full;
   logic [CW-1:0]    sb_count_next;
   sb_entry_t        sb_head;
   logic             store_go, load_go;

   commit_store_buffer #(
      .DEPTH(SB_DEPTH)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .push       (sb_push),
      .push_addr  (st_commit_addr),
      .push_data  (st_commit_data),
      .push_strb  (st_commit_strb),
      .pop        (store_go),
      .lookup_word(ld_req_addr[31:2]),
      .hit        (sb_hit),
      .empty      (sb_empty),
      .full       (sb_full),
      .count_next (sb_count_next),
      .head       (sb_head)
   );

   assign st_commit_ready = !sb_full;
   assign sb_push         = st_commit_valid && !sb_full;
   assign fence_done      = fence_req && sb_empty;
   assign ld_req_ready    = load_go;
   assign ld_rsp_valid    = rsp_valid_q;
   assign ld_rsp_tag      = rsp_tag_q;
   assign ld_rsp_data     = DM_rd_data;

   // The port stays idle for as long as reset is held.
   always_comb begin
      store_go = rst && sb_head.valid &&
                 (state_q == STORE_PRI ||
                  !ld_req_valid || sb_hit);
      load_go  = rst && ld_req_valid &&
                 !sb_hit && !store_go;
   end

   always_comb begin
      DM_c_en   = 1'b1;
      DM_r_en   = 1'b1;
      DM_w_en   = '1;
      DM_addr   = '0;
      DM_w_data = '0;
      unique case (1'b1)
         store_go: begin
            DM_c_en   = 1'b0;
            DM_r_en   = 1'b0;
            DM_w_en   = strb_to_wmask(sb_head.strb);
            DM_addr   = sb_head.addr;
            DM_w_data = sb_head.data;
         end
         load_go: begin
            DM_c_en = 1'b0;
            DM_addr = ld_req_addr;
         end
         default: ;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (sb_empty || store_go)
         starve_d = '0;
      else if (starve_q != SW'(STARVE_LIMIT))
         starve_d = starve_q + SW'(1);

      // Priority flips on the same edge the trigger is reached.
      state_d = state_q;
      unique case (state_q)
         LOAD_PRI:
            if (sb_count_next == CW'(SB_DEPTH) ||
                starve_d == SW'(STARVE_LIMIT) ||
                fence_req)
               state_d = STORE_PRI;
         STORE_PRI:
            if (sb_count_next == '0)
               state_d = LOAD_PRI;
            else if (store_go && !fence_req &&
                     sb_count_next != CW'(SB_DEPTH))
               state_d = LOAD_PRI;
         default:
            state_d = LOAD_PRI;
      endcase

      rsp_valid_d = load_go;
      rsp_tag_d   = load_go ? ld_req_tag : rsp_tag_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= LOAD_PRI;
         starve_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed scenarios plus random traffic for dm_port_arbiter,
// checked against a queue model of the store buffer and memory.
module tb_dm_port_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req_valid;
  logic [31:0] ld_req_addr;
  logic [1:0]  ld_req_tag;
  logic        ld_req_ready;
  logic        ld_rsp_valid;
  logic [1:0]  ld_rsp_tag;
  logic [31:0] ld_rsp_data;
  logic        st_commit_valid;
  logic [31:0] st_commit_addr;
  logic [31:0] st_commit_data;
  logic [3:0]  st_commit_strb;
  logic        st_commit_ready;
  logic        fence_req;
  logic        fence_done;
  logic [31:0] DM_rd_data = '0;
  logic        DM_c_en;
  logic        DM_r_en;
  logic [31:0] DM_w_en;
  logic [31:0] DM_addr;
  logic [31:0] DM_w_data;

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .SB_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT),
    .TAG_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_req_valid(ld_req_valid),
    .ld_req_addr(ld_req_addr),
    .ld_req_tag(ld_req_tag),
    .ld_req_ready(ld_req_ready),
    .ld_rsp_valid(ld_rsp_valid),
    .ld_rsp_tag(ld_rsp_tag),
    .ld_rsp_data(ld_rsp_data),
    .st_commit_valid(st_commit_valid),
    .st_commit_addr(st_commit_addr),
    .st_commit_data(st_commit_data),
    .st_commit_strb(st_commit_strb),
    .st_commit_ready(st_commit_ready),
    .fence_req(fence_req),
    .fence_done(fence_done),
    .DM_rd_data(DM_rd_data),
    .DM_c_en(DM_c_en),
    .DM_r_en(DM_r_en),
    .DM_w_en(DM_w_en),
    .DM_addr(DM_addr),
    .DM_w_data(DM_w_data)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int k = 0; k < 4; k++)
      if (s[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // Memory environment: one-cycle read latency.
  logic [31:0] envmem [256];
  logic [31:0] refmem [256];
  logic        env_cen = 1'b1;
  logic        env_ren = 1'b1;
  logic [31:0] env_wen, env_addr, env_wdata;

  always @(negedge clk) begin
    env_cen   = DM_c_en;
    env_ren   = DM_r_en;
    env_wen   = DM_w_en;
    env_addr  = DM_addr;
    env_wdata = DM_w_data;
  end

  always @(posedge clk) begin
    if (!env_cen) begin
      if (env_ren)
        DM_rd_data <= envmem[env_addr[9:2]];
      else
        envmem[env_addr[9:2]] =
          (envmem[env_addr[9:2]] & env_wen) |
          (env_wdata & ~env_wen);
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } st_t;

  st_t         sbq[$];
  bit          prio;
  int          starve;
  bit          rsp_v;
  logic [1:0]  rsp_tag;
  logic [31:0] rsp_data;
  bit          e_st, e_ld, e_push;

  int          n_chk, n_err;
  bit          obs_wr, obs_rd, obs_st_ready;
  bit          obs_fence_done, obs_rsp_valid;
  logic [31:0] obs_wen, obs_rsp_data;
  logic [1:0]  obs_rsp_tag;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_check();
    bit hit = 1'b0;
    foreach (sbq[i])
      if (sbq[i].a[31:2] == ld_req_addr[31:2]) hit = 1'b1;
    e_st = rst && sbq.size() > 0 &&
           (prio || !ld_req_valid || hit);
    e_ld = rst && ld_req_valid && !hit && !e_st;
    e_push = st_commit_valid && sbq.size() < DEPTH;

    check("ld_req_ready", 32'(ld_req_ready), 32'(e_ld));
    check("st_ready", 32'(st_commit_ready),
          32'(sbq.size() < DEPTH));
    check("fence_done", 32'(fence_done),
          32'(fence_req && sbq.size() == 0));
    check("dm_c_en", 32'(DM_c_en), 32'(!(e_st || e_ld)));
    check("dm_r_en", 32'(DM_r_en), 32'(!e_st));
    if (e_st) begin
      check("st_addr", DM_addr, sbq[0].a);
      check("st_wen", DM_w_en, ~byte_mask(sbq[0].s));
      check("st_wdata", DM_w_data, sbq[0].d);
    end else if (e_ld) begin
      check("ld_addr", DM_addr, ld_req_addr);
      check("ld_wen", DM_w_en, 32'hFFFF_FFFF);
    end else begin
      check("idle_addr", DM_addr, 32'h0);
      check("idle_wen", DM_w_en, 32'hFFFF_FFFF);
    end
    check("rsp_valid", 32'(ld_rsp_valid), 32'(rsp_v));
    if (rsp_v) begin
      check("rsp_tag", 32'(ld_rsp_tag), 32'(rsp_tag));
      check("rsp_data", ld_rsp_data, rsp_data);
    end

    obs_wr         = !DM_c_en && !DM_r_en;
    obs_rd         = !DM_c_en && DM_r_en;
    obs_st_ready   = st_commit_ready;
    obs_fence_done = fence_done;
    obs_rsp_valid  = ld_rsp_valid;
    obs_wen        = DM_w_en;
    obs_rsp_data   = ld_rsp_data;
    obs_rsp_tag    = ld_rsp_tag;
  endtask

  task automatic model_update();
    bit          busy;
    int          n;
    st_t         h;
    logic [31:0] bm;
    if (!rst) begin
      sbq.delete();
      prio   = 1'b0;
      starve = 0;
      rsp_v  = 1'b0;
      return;
    end
    busy  = sbq.size() > 0;
    rsp_v = e_ld;
    if (e_ld) begin
      rsp_tag  = ld_req_tag;
      rsp_data = refmem[ld_req_addr[9:2]];
    end
    if (e_st) begin
      h  = sbq.pop_front();
      bm = byte_mask(h.s);
      refmem[h.a[9:2]] = (refmem[h.a[9:2]] & ~bm) | (h.d & bm);
    end
    if (e_push)
      sbq.push_back('{st_commit_addr, st_commit_data,
                      st_commit_strb});
    if (!busy || e_st) starve = 0;
    else if (starve < LIMIT) starve++;
    n = sbq.size();
    if (!prio) begin
      if (n == DEPTH || starve == LIMIT || fence_req)
        prio = 1'b1;
    end else if (n == 0 ||
                 (e_st && !fence_req && n < DEPTH)) begin
      prio = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst             = 1'b1;
    ld_req_valid    = 1'b0;
    ld_req_addr     = '0;
    ld_req_tag      = '0;
    st_commit_valid = 1'b0;
    st_commit_addr  = '0;
    st_commit_data  = '0;
    st_commit_strb  = '0;
    fence_req       = 1'b0;
  endtask

  initial begin
    int nl, nw, nc;
    bit done;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) begin
      envmem[i] = init_word(i);
      refmem[i] = init_word(i);
    end

    // Reset holds the port idle even with requests present.
    idle();
    rst             = 1'b0;
    ld_req_valid    = 1'b1;
    ld_req_addr     = 32'h100;
    st_commit_valid = 1'b1;
    cycle();
    cycle();
    check("rst_no_read", 32'(obs_rd), 32'h0);
    check("rst_no_rsp", 32'(obs_rsp_valid), 32'h0);

    // Load only.
    idle();
    cycle();
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'h100;
    ld_req_tag   = 2'd2;
    cycle();
    check("lo_read", 32'(obs_rd), 32'h1);
    ld_req_valid = 1'b0;
    cycle();
    check("lo_rsp_valid", 32'(obs_rsp_valid), 32'h1);
    check("lo_rsp_tag", 32'(obs_rsp_tag), 32'h2);
    check("lo_rsp_data", obs_rsp_data, init_word(32'h40));

    // Hazard on a pending word.
    idle();
    st_commit_valid = 1'b1;
    st_commit_addr  = 32'h104;
    st_commit_data  = 32'h1234_BEEF;
    st_commit_strb  = 4'b0011;
    cycle();
    st_commit_valid = 1'b0;
    ld_req_valid    = 1'b1;
    ld_req_addr     = 32'h106;
    ld_req_tag      = 2'd1;
    cycle();
    check("hz_blocked", 32'(obs_rd), 32'h0);
    check("hz_write", 32'(obs_wr), 32'h1);
    check("hz_wen", obs_wen, 32'hFFFF_0000);
    cycle();
    check("hz_load_issue", 32'(obs_rd), 32'h1);
    ld_req_valid = 1'b0;
    cycle();
    check("hz_rsp_data", obs_rsp_data,
          {init_word(32'h41) >> 16, 16'hBEEF});

    // Starvation bound.
    idle();
    repeat (2) cycle();
    st_commit_valid = 1'b1;
    st_commit_addr  = 32'h200;
    st_commit_data  = 32'hCAFE_0001;
    st_commit_strb  = 4'hF;
    cycle();
    st_commit_valid = 1'b0;
    ld_req_valid    = 1'b1;
    nl   = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      ld_req_addr = 32'h300 + 32'(4 * (i % 8));
      ld_req_tag  = 2'(i);
      cycle();
      if (obs_wr) done = 1'b1;
      else if (obs_rd) nl++;
    end
    check("starve_write_seen", 32'(done), 32'h1);
    check("starve_loads", 32'(nl), 32'd8);

    // Full buffer forces store priority.
    idle();
    repeat (2) cycle();
    ld_req_valid    = 1'b1;
    ld_req_addr     = 32'h340;
    st_commit_valid = 1'b1;
    st_commit_strb  = 4'hF;
    for (int i = 0; i < 4; i++) begin
      st_commit_addr = 32'h240 + 32'(4 * i);
      st_commit_data = 32'h5000 + 32'(i);
      cycle();
    end
    st_commit_addr = 32'h250;
    st_commit_data = 32'h5004;
    cycle();
    check("full_ready", 32'(obs_st_ready), 32'h0);
    check("full_write", 32'(obs_wr), 32'h1);
    cycle();
    check("full_ready_after_pop", 32'(obs_st_ready), 32'h1);
    idle();
    repeat (6) cycle();

    // Fence drain.
    ld_req_valid    = 1'b1;
    ld_req_addr     = 32'h380;
    st_commit_valid = 1'b1;
    st_commit_strb  = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      st_commit_addr = 32'h280 + 32'(4 * i);
      st_commit_data = 32'h7700_0000 + 32'(i);
      cycle();
    end
    st_commit_valid = 1'b0;
    ld_req_valid    = 1'b0;
    fence_req       = 1'b1;
    nw = 0; nl = 0; nc = 0;
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      cycle();
      nc++;
      if (obs_fence_done) done = 1'b1;
      else begin
        nw += int'(obs_wr);
        nl += int'(obs_rd);
      end
      ld_req_valid = 1'b1;
    end
    fence_req = 1'b0;
    check("fence_writes", 32'(nw), 32'd3);
    check("fence_loads", 32'(nl), 32'd0);
    check("fence_cycles", 32'(nc), 32'd4);
    idle();
    repeat (2) cycle();

    // Reset with buffered stores and a pending response.
    ld_req_valid    = 1'b1;
    ld_req_addr     = 32'h3C0;
    st_commit_valid = 1'b1;
    st_commit_strb  = 4'hF;
    st_commit_addr  = 32'h2C0;
    cycle();
    st_commit_addr  = 32'h2C4;
    cycle();
    st_commit_valid = 1'b0;
    rst             = 1'b0;
    cycle();
    check("rst_mid_idle", 32'(obs_rd || obs_wr), 32'h0);
    rst          = 1'b1;
    ld_req_valid = 1'b0;
    cycle();
    check("rst_mid_no_write", 32'(obs_wr), 32'h0);
    check("rst_mid_st_ready", 32'(obs_st_ready), 32'h1);
    check("rst_mid_rsp", 32'(obs_rsp_valid), 32'h0);

    // Random traffic on a small address window.
    idle();
    for (int c = 0; c < 3000; c++) begin
      ld_req_valid   = ($urandom_range(0, 9) < 6);
      ld_req_addr    = {26'h0, 4'($urandom_range(0, 15)),
                        2'($urandom)};
      ld_req_tag     = 2'($urandom);
      st_commit_valid = ($urandom_range(0, 9) < 4);
      st_commit_addr = {26'h0, 4'($urandom_range(0, 15)),
                        2'b00};
      st_commit_data = $urandom;
      st_commit_strb = 4'($urandom_range(1, 15));
      if (fence_req && obs_fence_done)
        fence_req = 1'b0;
      else if (!fence_req && $urandom_range(0, 31) == 0)
        fence_req = 1'b1;
      rst = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
